alu_sched: RTL and testbench
============================

// Module: alu_sched
// PURPOSE
//  Shares one alu instance between two requesters (0: core, 1: microcode/aux).
//  Arbitrates round-robin, latches operands and op, sequences the ALU strobes
//  (ai/bi/oe/sel) over a fixed multi-cycle schedule, and returns the result and
//  flags to the winning requester over a valid/ready response channel.
// PARAMETERS
//  WIDTH        16  operand/result width (matches alu a/b/out)
//  FLAGS_W       7  alu flags width, passed through opaque
//  EXEC_CYCLES   1  EXEC cycles for sel=00/01/11 (>=1)
//  MUL_CYCLES    3  EXEC cycles for sel=10 multiply (>=1)
// PORTS
//  clk         in   1        clock, all state on rising edge
//  rst_n       in   1        asynchronous active-low reset
//  reqN_valid  in   1        N=0,1: request present; held stable until reqN_ready
//  reqN_ready  out  1        N=0,1: request accepted this cycle
//  reqN_op     in   2        N=0,1: alu sel code (00 add,01 sub,10 mul,11 nand)
//  reqN_a      in   WIDTH    N=0,1: operand a
//  reqN_b      in   WIDTH    N=0,1: operand b
//  rspN_valid  out  1        N=0,1: result available for requester N
//  rspN_ready  in   1        N=0,1: requester consumes result
//  rsp_data    out  WIDTH    result, shared, valid with either rspN_valid
//  rsp_flags   out  FLAGS_W  captured alu flags, shared
//  alu_ai      out  1        operand-a load strobe to alu
//  alu_bi      out  1        operand-b load strobe to alu
//  alu_oe      out  1        alu output enable
//  alu_sel     out  2        alu op select
//  alu_a       out  WIDTH    alu operand a (from operand register)
//  alu_b       out  WIDTH    alu operand b (from operand register)
//  alu_out     in   WIDTH    alu result
//  alu_flags   in   FLAGS_W  alu flags
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; operand/op/result/flag regs 0; rr pointer
//   favours requester 0.
//  FSM IDLE->LOAD->EXEC->RESP->IDLE.
//  IDLE: grant = round-robin over reqN_valid; reqN_ready=1 combinationally for
//   the granted requester only; on that edge latch op/a/b and owner; go LOAD.
//   Both valid: grant the requester not granted last; rr updates on accept.
//  LOAD (1 cycle): alu_ai=alu_bi=1; alu_a/alu_b/alu_sel driven from regs
//   (driven from regs in all non-IDLE states).
//  EXEC: N = MUL_CYCLES if op==10 else EXEC_CYCLES; down-counter; alu_oe=1 in
//   all EXEC cycles; on final EXEC edge capture alu_out->rsp_data and
//   alu_flags->rsp_flags; go RESP.
//  RESP: rspOwner_valid=1, data/flags stable; leave on rsp_valid&&rsp_ready;
//   other rsp_valid stays 0. rspN_ready ignored when rspN_valid=0.
//  Latency: accept edge k -> rsp_valid high from cycle k+2+N. No accept in
//   the RESP-exit cycle; next accept earliest the following cycle.
//  Requests arriving outside IDLE wait (ready=0); no queueing.
//  Width: result is alu_out as given (mul truncated to WIDTH by alu).
//  Async reset mid-operation aborts: pending result dropped, no rsp_valid.
// TESTING
//  req0 op=00 a=0x0003 b=0x0004, EXEC_CYCLES=1 -> rsp0_valid at k+3, data 0x0007.
//  req1 op=01 a=0x0000 b=0x0001 -> rsp1_valid only, rsp_data 0xFFFF; rsp0_valid=0.
//  req0 op=10 a=0x0100 b=0x0100, MUL_CYCLES=3 -> rsp at k+5, data 0x0000;
//   alu_oe high exactly 3 cycles.
//  req0 op=11 a=0xFFFF b=0x00FF, rsp0_ready low 10 cycles -> data 0xFF00 held,
//   rsp0_valid held, req1_ready stays 0 throughout.
//  req0,req1 valid continuously from reset -> grant order 0,1,0,1; alu_ai/bi
//   pulse once per op.
//  rst_n low during EXEC -> all outputs 0 asynchronously; no rsp_valid after
//   release; next request served with normal latency.

Source files
------------

// File: rtl/alu_sched.sv
// alu_sched: shares a single multi-cycle ALU between two requesters.
//   Requester 0 is the core and requester 1 is microcode/aux.
//   Arbitration is round-robin. The winner's op and operands are latched,
//   the ALU is strobed through LOAD -> EXEC, and the result and flags are
//   returned on that requester's valid/ready response channel.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   reqN_valid/ready/op/a/b     request channel per requester (N=0,1)
//   rspN_valid/ready            response handshake per requester
//   rsp_data, rsp_flags         shared captured result/flags
//   alu_ai/bi/oe/sel/a/b        strobes and operands driven to the ALU
//   alu_out, alu_flags          ALU result/flags
module alu_sched #(
   parameter int WIDTH       = 16,
   parameter int FLAGS_W     = 7,
   parameter int EXEC_CYCLES = 1,
   parameter int MUL_CYCLES  = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               req0_valid,
   output logic               req0_ready,
   input  logic [1:0]         req0_op,
   input  logic [WIDTH-1:0]   req0_a,
   input  logic [WIDTH-1:0]   req0_b,
   input  logic               req1_valid,
   output logic               req1_ready,
   input  logic [1:0]         req1_op,
   input  logic [WIDTH-1:0]   req1_a,
   input  logic [WIDTH-1:0]   req1_b,
   output logic               rsp0_valid,
   input  logic               rsp0_ready,
   output logic               rsp1_valid,
   input  logic               rsp1_ready,
   output logic [WIDTH-1:0]   rsp_data,
   output logic [FLAGS_W-1:0] rsp_flags,
   output logic               alu_ai,
   output logic               alu_bi,
   output logic               alu_oe,
   output logic [1:0]         alu_sel,
   output logic [WIDTH-1:0]   alu_a,
   output logic [WIDTH-1:0]   alu_b,
   input  logic [WIDTH-1:0]   alu_out,
   input  logic [FLAGS_W-1:0] alu_flags
);

   localparam int MAXC = (MUL_CYCLES > EXEC_CYCLES) ? MUL_CYCLES : EXEC_CYCLES;
   localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

   typedef enum logic [1:0] {IDLE, LOAD, EXEC, RESP} state_t;

   state_t           state;
   logic [1:0]       op_r;
   logic [WIDTH-1:0] a_r, b_r;
   logic             owner;   // requester being served
   logic             pri;     // requester favoured on a tie
   logic [CW-1:0]    cnt;     // remaining EXEC cycles minus one
   logic             gnt0, gnt1;
   logic             rsp_hs;

   // Grant is combinational so ready can be raised in the same cycle.
   // It is gated by rst_n so every output reads 0 while reset is held.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (state == IDLE && rst_n) begin
         if (req0_valid && req1_valid) begin
            gnt0 = ~pri;
            gnt1 = pri;
         end else begin
            gnt0 = req0_valid;
            gnt1 = req1_valid;
         end
      end
   end

   assign req0_ready = gnt0;
   assign req1_ready = gnt1;
   assign rsp_hs     = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);

   // The operand registers keep their values after the response completes.
   // The ALU-facing buses are forced to 0 in IDLE so the ALU sees nothing stale.
   assign alu_a   = (state != IDLE) ? a_r  : '0;
   assign alu_b   = (state != IDLE) ? b_r  : '0;
   assign alu_sel = (state != IDLE) ? op_r : 2'b00;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         op_r       <= '0;
         a_r        <= '0;
         b_r        <= '0;
         owner      <= 1'b0;
         pri        <= 1'b0;
         cnt        <= '0;
         alu_ai     <= 1'b0;
         alu_bi     <= 1'b0;
         alu_oe     <= 1'b0;
         rsp0_valid <= 1'b0;
         rsp1_valid <= 1'b0;
         rsp_data   <= '0;
         rsp_flags  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (gnt0 || gnt1) begin
                  owner  <= gnt1;
                  op_r   <= gnt1 ? req1_op : req0_op;
                  a_r    <= gnt1 ? req1_a  : req0_a;
                  b_r    <= gnt1 ? req1_b  : req0_b;
                  pri    <= gnt0;   // the other requester wins the next tie
                  alu_ai <= 1'b1;
                  alu_bi <= 1'b1;
                  state  <= LOAD;
               end
            end
            LOAD: begin
               alu_ai <= 1'b0;
               alu_bi <= 1'b0;
               alu_oe <= 1'b1;
               cnt    <= (op_r == 2'b10) ? CW'(MUL_CYCLES - 1) : CW'(EXEC_CYCLES - 1);
               state  <= EXEC;
            end
            EXEC: begin
               if (cnt == '0) begin
                  rsp_data   <= alu_out;
                  rsp_flags  <= alu_flags;
                  alu_oe     <= 1'b0;
                  rsp0_valid <= ~owner;
                  rsp1_valid <= owner;
                  state      <= RESP;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            RESP: begin
               if (rsp_hs) begin
                  rsp0_valid <= 1'b0;
                  rsp1_valid <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_sched.sv
// tb_alu_sched: directed and randomized checks of alu_sched against a
// behavioural model. The bench includes a small ALU model that latches its
// operands on ai/bi and drives its result only while oe is high.
module tb_alu_sched;

   localparam int W = 16;
   localparam int F = 7;
   localparam int EXC = 1;
   localparam int MULC = 3;

   logic         clk, rst_n;
   logic         req0_valid, req0_ready, req1_valid, req1_ready;
   logic [1:0]   req0_op, req1_op;
   logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
   logic         rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
   logic [W-1:0] rsp_data;
   logic [F-1:0] rsp_flags;
   logic         alu_ai, alu_bi, alu_oe;
   logic [1:0]   alu_sel;
   logic [W-1:0] alu_a, alu_b, alu_out;
   logic [F-1:0] alu_flags;

   int checks = 0;
   int passed = 0;

   alu_sched #(.WIDTH(W), .FLAGS_W(F), .EXEC_CYCLES(EXC), .MUL_CYCLES(MULC)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
      .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
      .req1_a(req1_a), .req1_b(req1_b),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
      .rsp_data(rsp_data), .rsp_flags(rsp_flags),
      .alu_ai(alu_ai), .alu_bi(alu_bi), .alu_oe(alu_oe), .alu_sel(alu_sel),
      .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out), .alu_flags(alu_flags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---- reference functions ----
   function automatic logic [W-1:0] f_res(input logic [1:0] op, input logic [W-1:0] a, b);
      logic [31:0] p;
      case (op)
         2'b00: f_res = a + b;
         2'b01: f_res = a - b;
         2'b10: begin p = a * b; f_res = p[W-1:0]; end
         default: f_res = ~(a & b);
      endcase
   endfunction

   function automatic logic [F-1:0] f_flg(input logic [1:0] op, input logic [W-1:0] r);
      f_flg = {op, (r == '0), r[W-1], r[2:0]};
   endfunction

   function automatic int f_lat(input logic [1:0] op);
      f_lat = 2 + ((op == 2'b10) ? MULC : EXC);
   endfunction

   // ---- ALU model ----
   logic [W-1:0] la = '0, lb = '0;
   always @(posedge clk) begin
      if (alu_ai) la <= alu_a;
      if (alu_bi) lb <= alu_b;
   end
   assign alu_out   = alu_oe ? f_res(alu_sel, la, lb) : '0;
   assign alu_flags = alu_oe ? f_flg(alu_sel, f_res(alu_sel, la, lb)) : '0;

   // ---- helpers ----
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) begin
         passed++;
      end else begin
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   function automatic logic [63:0] all_outs();
      all_outs = {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data, rsp_flags,
                  alu_ai, alu_bi, alu_oe, alu_sel, alu_a, alu_b};
   endfunction

   task automatic set_req(input int id, input logic v, input logic [1:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] b);
      if (id == 0) begin
         req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
      end else begin
         req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
      end
   endtask

   // One complete transaction for requester id, started at a sample point in IDLE.
   task automatic do_op(input int id, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int hold, input bit poke);
      logic [W-1:0] er;
      bit           found, bad;
      int           c, ai, oe;
      er = f_res(op, a, b);
      set_req(id, 1'b1, op, a, b);
      #1;
      found = 0;
      for (int i = 0; i < 20; i++) begin
         if ((id == 0) ? req0_ready : req1_ready) begin found = 1; break; end
         step();
      end
      chk("accept", 64'(found), 64'd1);
      chk("other_ready", 64'((id == 0) ? req1_ready : req0_ready), 64'd0);
      step();
      set_req(id, 1'b0, op, a, b);
      c = 1; ai = 0; oe = 0; bad = 0;
      while (!((id == 0) ? rsp0_valid : rsp1_valid) && c < 40) begin
         if (alu_ai && alu_bi) ai++;
         if (alu_oe) oe++;
         if (rsp0_valid || rsp1_valid) bad = 1;
         step();
         c++;
      end
      chk("latency", 64'(c), 64'(f_lat(op)));
      chk("ai_bi_pulses", 64'(ai), 64'd1);
      chk("oe_cycles", 64'(oe), 64'(f_lat(op) - 2));
      chk("early_rsp", 64'(bad), 64'd0);
      chk("rsp_data", 64'(rsp_data), 64'(er));
      chk("rsp_flags", 64'(rsp_flags), 64'(f_flg(op, er)));
      chk("other_rsp_valid", 64'((id == 0) ? rsp1_valid : rsp0_valid), 64'd0);
      if (poke) set_req(1 - id, 1'b1, 2'b00, 16'h1234, 16'h4321);
      bad = 0;
      for (int h = 0; h < hold; h++) begin
         #1;
         if (!((id == 0) ? rsp0_valid : rsp1_valid)) bad = 1;
         if (rsp_data !== er) bad = 1;
         if (req0_ready || req1_ready) bad = 1;
         step();
      end
      chk("hold_stable", 64'(bad), 64'd0);
      if (poke) set_req(1 - id, 1'b0, 2'b00, 16'h0, 16'h0);
      if (id == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
      step();
      chk("rsp_done", 64'({rsp0_valid, rsp1_valid}), 64'd0);
      rsp0_ready = 1'b0;
      rsp1_ready = 1'b0;
   endtask

   initial begin
      logic [1:0]    gq[$];
      logic [1:0]    oq[$];
      logic [33:0]   eq[$];
      logic [33:0]   e;
      logic [W-1:0]  er;
      logic [W-1:0]  ra, rb;
      int            nacc, nrsp, ai;
      bit            both, renew0, renew1, bad;

      // reset with both requesters already valid
      rst_n = 1'b0;
      set_req(0, 1'b1, 2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom));
      set_req(1, 1'b1, 2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom));
      rsp0_ready = 1'b1;
      rsp1_ready = 1'b1;
      step();
      step();
      chk("reset_outputs", all_outs(), 64'd0);

      // round-robin with both requesters valid continuously
      rst_n = 1'b1;
      #1;
      nacc = 0; nrsp = 0; ai = 0; both = 0; renew0 = 0; renew1 = 0;
      for (int c = 0; c < 80 && nrsp < 4; c++) begin
         if (renew0) begin
            set_req(0, 1'b1, 2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom));
            renew0 = 0;
         end
         if (renew1) begin
            set_req(1, 1'b1, 2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom));
            renew1 = 0;
         end
         #1;
         if (alu_ai) ai++;
         if (req0_ready && req1_ready) both = 1;
         if (req0_ready) begin
            gq.push_back(2'd0); oq.push_back(2'd0);
            eq.push_back({req0_op, req0_a, req0_b}); nacc++; renew0 = 1;
         end else if (req1_ready) begin
            gq.push_back(2'd1); oq.push_back(2'd1);
            eq.push_back({req1_op, req1_a, req1_b}); nacc++; renew1 = 1;
         end
         if (rsp0_valid || rsp1_valid) begin
            e  = (eq.size() > 0) ? eq.pop_front() : '0;
            er = f_res(e[33:32], e[31:16], e[15:0]);
            chk("arb_owner", 64'({rsp1_valid, rsp0_valid}),
                64'((oq.size() > 0 && oq.pop_front() == 2'd1) ? 2'b10 : 2'b01));
            chk("arb_data", 64'(rsp_data), 64'(er));
            chk("arb_flags", 64'(rsp_flags), 64'(f_flg(e[33:32], er)));
            nrsp++;
         end
         step();
      end
      chk("arb_rsp_count", 64'(nrsp), 64'd4);
      chk("arb_never_both", 64'(both), 64'd0);
      chk("arb_order", 64'((gq.size() >= 4) ? {gq[0][0], gq[1][0], gq[2][0], gq[3][0]} : 4'hf),
          64'b0101);
      chk("arb_ai_pulses", 64'(ai), 64'(nacc));
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      step();
      rsp0_ready = 1'b0;
      rsp1_ready = 1'b0;
      step();

      // directed cases
      do_op(0, 2'b00, 16'h0003, 16'h0004, 0, 0);
      do_op(1, 2'b01, 16'h0000, 16'h0001, 0, 0);
      do_op(0, 2'b10, 16'h0100, 16'h0100, 0, 0);
      do_op(0, 2'b11, 16'hFFFF, 16'h00FF, 10, 1);

      // randomized transactions
      for (int t = 0; t < 16; t++)
         do_op(int'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 16'($urandom),
               16'($urandom), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));

      // async reset in the middle of EXEC
      ra = 16'($urandom);
      rb = 16'($urandom);
      set_req(0, 1'b1, 2'b10, ra, rb);
      #1;
      chk("mid_accept", 64'(req0_ready), 64'd1);
      step();
      set_req(0, 1'b0, 2'b10, ra, rb);
      step();
      chk("mid_in_exec", 64'(alu_oe), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_reset_outputs", all_outs(), 64'd0);
      step();
      rst_n = 1'b1;
      rsp0_ready = 1'b0;
      bad = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (rsp0_valid || rsp1_valid || alu_oe) bad = 1;
      end
      chk("mid_no_rsp", 64'(bad), 64'd0);
      do_op(0, 2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom), 1, 0);
      do_op(1, 2'b10, 16'($urandom), 16'($urandom), 0, 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
